serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL take one parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to add the present a/b/cin.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the registered result.
REQ-011 The block SHALL have port cout, output, 1 bit, the registered carry-out.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, the block SHALL accept start=1 at the next edge: load A/B shift registers from a/b, load the carry flop from cin, clear the bit counter, go to SHIFT.
REQ-014 In SHIFT, each edge SHALL:
- feed the LSBs of A/B and the carry flop to one full-adder instance;
- shift the sum bit into the MSB of the result shift register;
- shift A/B right by one;
- capture the full-adder carry-out into the carry flop;
- increment the counter.
REQ-015 On the edge that processes bit WIDTH-1, the block SHALL copy the result shift register to sum and the carry-out to cout, and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: if start is sampled at edge 0, done is high during the cycle after edge WIDTH+1 and falls at edge WIDTH+2.
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 start SHALL be ignored in SHIFT and DONE; operands are not re-sampled; no error is flagged.
REQ-020 sum and cout SHALL hold their last values until the next completion; partial results SHALL never appear on sum.
REQ-021 The result SHALL equal {cout,sum} = a + b + cin computed at WIDTH+1 bits; overflow wraps sum and sets cout.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap inside an operation.

Reset
REQ-023 When rst=1 at an edge, the block SHALL force IDLE, busy=0, done=0, sum=0, cout=0, and clear the shift registers, carry flop and counter, regardless of state.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 Reset mid-SHIFT SHALL abandon the operation without asserting done.
REQ-026 A start asserted in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default.
REQ-028 The design SHALL contain exactly one sub-module instance: the existing combinational fulladder, with ports a, b, cin, sumf, coutf; no other adder logic SHALL exist in the block.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Verification (WIDTH=8 unless stated)
REQ-030 The bench SHALL cover: a=8'h00, b=8'h00, cin=0, start pulsed -> busy high for 8 cycles; done one cycle with sum=8'h00, cout=0; done at edge 9 after the start sample.
REQ-031 The bench SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (wrap).
REQ-032 The bench SHALL cover: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1; then a=8'h5A, b=8'h25, cin=0 -> sum=8'h7F, cout=0; sum holds 8'hFF until the second done.
REQ-033 The bench SHALL cover: start with a=8'h10, b=8'h20, then start again on SHIFT cycle 3 with a=8'hFF, b=8'hFF -> second start ignored; result sum=8'h30, cout=0.
REQ-034 The bench SHALL cover: start a=8'h0F, b=8'h01, then rst=1 on SHIFT cycle 4 -> next cycle busy=0, done=0, sum=8'h00, cout=0, no done pulse; a fresh start then gives sum=8'h10.
REQ-035 The bench SHALL cover: WIDTH=3, all 128 combinations of a, b and cin, one after another -> every {cout,sum} equals a+b+cin and every done arrives exactly 4 edges after its start sample.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sumf,
  output logic coutf
);
  assign sumf  = a ^ b ^ cin;
  assign coutf = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock through a single full adder, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Result shifter holds only the WIDTH-1 bits already produced; the
  // current full-adder sum bit completes it on the final edge.
  logic [WIDTH-1:1] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_next;

  fulladder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_c),
    .sumf (w_s),
    .coutf(w_co)
  );

  assign w_next = {w_s, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_res <= w_next[WIDTH-1:1];
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_co;
          if (r_cnt == LAST) begin
            sum     <= w_next;
            cout    <= w_co;
            busy    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // done is registered, so the pulse is visible in the cycle after DONE
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and an exhaustive sweep at WIDTH=3.
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8, c8, s3, c3;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;
  logic       busy8, done8, cout8, busy3, done3, cout3;
  logic [7:0] sum8;
  logic [2:0] sum3;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .cin(c3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (edge 0) and watch edges 0..19.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co,
                      output int lat, output int bc, output int dc);
    a8 = a; b8 = b; c8 = c; s8 = 1'b1;
    lat = -1; bc = 0; dc = 0; s = 'x; co = 1'bx;
    for (int e = 0; e < 20; e++) begin
      tick();
      s8 = 1'b0;
      if (busy8) bc++;
      if (done8) begin
        dc++;
        if (lat < 0) begin lat = e; s = sum8; co = cout8; end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] s; logic co; int lat, bc, dc;
    rst = 1'b1; s8 = 1'b1; s3 = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; a3 = 3'd5; b3 = 3'd2; c3 = 1'b1;
    tick(); tick();
    n_chk++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_chk++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_chk++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum8); end
    n_chk++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout8); end
    n_chk++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy3 got %b want 0", busy3); end
    s3 = 1'b0;
    rst = 1'b0;
    // start in the first cycle after release must be accepted
    run8(8'h03, 8'h04, 1'b1, s, co, lat, bc, dc);
    n_chk++; if (s !== 8'h08 || co !== 1'b0) begin n_fail++; $display("FAIL post_reset_start got %b_%h want 0_08", co, s); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL post_reset_latency got %0d want 9", lat); end
  endtask

  task automatic test_zero();
    logic [7:0] s; logic co; int lat, bc, dc;
    run8(8'h00, 8'h00, 1'b0, s, co, lat, bc, dc);
    n_chk++; if (bc !== 8) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 8", bc); end
    n_chk++; if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycles got %0d want 1", dc); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL zero_latency got %0d want 9", lat); end
    n_chk++; if (s !== 8'h00 || co !== 1'b0) begin n_fail++; $display("FAIL zero_result got %b_%h want 0_00", co, s); end
  endtask

  task automatic test_wrap();
    logic [7:0] s; logic co; int lat, bc, dc;
    run8(8'hFF, 8'h01, 1'b0, s, co, lat, bc, dc);
    n_chk++; if (s !== 8'h00 || co !== 1'b1) begin n_fail++; $display("FAIL wrap_result got %b_%h want 1_00", co, s); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL wrap_latency got %0d want 9", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic co; int lat, bc, dc, bad;
    run8(8'hFF, 8'hFF, 1'b1, s, co, lat, bc, dc);
    n_chk++; if (s !== 8'hFF || co !== 1'b1) begin n_fail++; $display("FAIL max_result got %b_%h want 1_FF", co, s); end
    a8 = 8'h5A; b8 = 8'h25; c8 = 1'b0; s8 = 1'b1;
    bad = 0; lat = -1; s = 'x; co = 1'bx;
    for (int e = 0; e < 20; e++) begin
      tick();
      s8 = 1'b0;
      if (busy8 && sum8 !== 8'hFF) bad++;
      if (done8 && lat < 0) begin lat = e; s = sum8; co = cout8; end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL hold_sum got %0d cycles changed want 0", bad); end
    n_chk++; if (s !== 8'h7F || co !== 1'b0) begin n_fail++; $display("FAIL second_result got %b_%h want 0_7F", co, s); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL second_latency got %0d want 9", lat); end
  endtask

  task automatic test_ignore_start();
    logic [7:0] s; logic co; int lat, dc;
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; s8 = 1'b1;
    tick();                     // edge 0
    s8 = 1'b0;
    tick(); tick();             // edges 1, 2
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    tick();                     // edge 3 sees start during SHIFT
    s8 = 1'b0;
    lat = -1; dc = 0; s = 'x; co = 1'bx;
    for (int e = 4; e < 24; e++) begin
      tick();
      if (done8) begin
        dc++;
        if (lat < 0) begin lat = e; s = sum8; co = cout8; end
      end
    end
    n_chk++; if (s !== 8'h30 || co !== 1'b0) begin n_fail++; $display("FAIL ignore_result got %b_%h want 0_30", co, s); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL ignore_latency got %0d want 9", lat); end
    n_chk++; if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_cycles got %0d want 1", dc); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] s; logic co; int lat, bc, dc;
    a8 = 8'h0F; b8 = 8'h01; c8 = 1'b0; s8 = 1'b1;
    tick();                     // edge 0
    s8 = 1'b0;
    tick(); tick(); tick();     // now in SHIFT cycle 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy8, done8); end
    n_chk++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin n_fail++; $display("FAIL midrst_result got %b_%h want 0_00", cout8, sum8); end
    dc = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done8 || busy8) dc++;
    end
    n_chk++; if (dc !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", dc); end
    run8(8'h0F, 8'h01, 1'b0, s, co, lat, bc, dc);
    n_chk++; if (s !== 8'h10 || co !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh got %b_%h want 0_10", co, s); end
  endtask

  task automatic test_width3_sweep();
    logic [3:0] exp_r, got;
    int lat;
    for (int i = 0; i < 128; i++) begin
      a3 = i[2:0]; b3 = i[5:3]; c3 = i[6]; s3 = 1'b1;
      exp_r = {1'b0, i[2:0]} + {1'b0, i[5:3]} + {3'b000, i[6]};
      lat = -1; got = 'x;
      for (int e = 0; e < 8; e++) begin
        tick();
        s3 = 1'b0;
        if (done3 && lat < 0) begin lat = e; got = {cout3, sum3}; end
      end
      n_chk++; if (got !== exp_r) begin n_fail++; $display("FAIL w3_result a=%0d b=%0d cin=%0d got %0d want %0d", a3, b3, c3, got, exp_r); end
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL w3_latency a=%0d b=%0d cin=%0d got %0d want 4", a3, b3, c3, lat); end
    end
  endtask

  initial begin
    rst = 1'b1; s8 = 1'b0; s3 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0; a3 = '0; b3 = '0; c3 = 1'b0;
    test_reset();
    test_zero();
    test_wrap();
    test_back_to_back();
    test_ignore_start();
    test_mid_reset();
    test_width3_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
